johnson_seq_ctrl: RTL and testbench

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

---
 rtl/jseq_pkg.sv | 17 +
 rtl/johnson_core.sv | 31 +++
 rtl/johnson_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jseq_pkg.sv
// jseq_pkg: shared types and default sizes for the Johnson sequence controller.
//   jseq_state_t     controller FSM state encoding
//   JSEQ_N_DEF       default Johnson phase width (period 2*N steps)
//   JSEQ_CNT_W_DEF   default width of the rotation-count request
package jseq_pkg;

   localparam int unsigned JSEQ_N_DEF     = 4;
   localparam int unsigned JSEQ_CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } jseq_state_t;

endpackage : jseq_pkg

// File: rtl/johnson_core.sv
// johnson_core: N-bit Johnson (twisted-ring) phase register.
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset, phase -> 0
//   step_en  advance one Johnson step this edge
//   clr      synchronous clear to the all-zero seed (wins over step_en)
//   phase    current phase pattern
module johnson_core
   import jseq_pkg::*;
#(
   parameter int unsigned N = JSEQ_N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step_en,
   input  logic         clr,
   output logic [N-1:0] phase
);

   // Inverted LSB feeds the MSB; the rest shifts down one place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (step_en) begin
         phase <= {~phase[0], phase[N-1:1]};
      end
   end

endmodule : johnson_core

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson phase sequence for a requested number of
// full 2*N-step rotations, with hold (pause) and abort.
// Optional feature: define JSEQ_ILLEGAL_DET_EN to enable the illegal-phase
// checker (sticky err, phase cleared, return to IDLE). Without it err is 0.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      request a sequence (sampled only in IDLE)
//   rotations  rotation count, captured with start
//   hold       freeze stepping while high
//   abort      terminate the sequence without done
//   phase      current Johnson phase pattern
//   busy       high while running or paused
//   done       one-cycle completion pulse
//   rot_left   rotations remaining, including the one in progress
//   err        sticky illegal-phase flag
module johnson_seq_ctrl
   import jseq_pkg::*;
#(
   parameter int unsigned N     = JSEQ_N_DEF,
   parameter int unsigned CNT_W = JSEQ_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] rotations,
   input  logic             hold,
   input  logic             abort,
   output logic [N-1:0]     phase,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rot_left,
   output logic             err
);

   localparam int unsigned STEP_W    = $clog2(2 * N);
   localparam int unsigned STEP_LAST = 2 * N - 1;

   jseq_state_t       state_q;
   jseq_state_t       state_d;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_d;
   logic [CNT_W-1:0]  rot_left_q;
   logic [CNT_W-1:0]  rot_left_d;
   logic              busy_q;
   logic              done_q;
   logic              step_en_c;
   logic              clr_c;
   logic              illegal_c;
   logic              accept_c;
   logic              last_c;

   assign accept_c = start & ~abort;
   // Final step of the final rotation.
   assign last_c   = (step_q == STEP_W'(STEP_LAST)) && (rot_left_q == CNT_W'(1));

`ifdef JSEQ_ILLEGAL_DET_EN
   localparam int unsigned TW = N - 1;

   logic [TW-1:0] trans_c;
   logic          err_q;

   // Legal Johnson patterns have at most one boundary between adjacent bits.
   assign trans_c   = phase[N-2:0] ^ phase[N-1:1];
   assign illegal_c = |(trans_c & (trans_c - TW'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (illegal_c) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign illegal_c = 1'b0;
   assign err       = 1'b0;
`endif

   johnson_core #(
      .N (N)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .step_en (step_en_c),
      .clr     (clr_c),
      .phase   (phase)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: illegal phase > abort > hold > stepping.
   always_comb begin
      state_d = state_q;
      if (illegal_c) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  state_d = (rotations == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_d = ST_IDLE;
               end else if (hold) begin
                  state_d = ST_PAUSE;
               end else if (last_c) begin
                  state_d = ST_DONE;
               end
            end
            ST_PAUSE: begin
               if (abort) begin
                  state_d = ST_IDLE;
               end else if (!hold) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath controls and counter updates.
   always_comb begin
      step_en_c  = 1'b0;
      clr_c      = 1'b0;
      step_d     = step_q;
      rot_left_d = rot_left_q;
      if (illegal_c) begin
         clr_c      = 1'b1;
         step_d     = '0;
         rot_left_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c && (rotations != '0)) begin
                  step_d     = '0;
                  rot_left_d = rotations;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  clr_c      = 1'b1;
                  step_d     = '0;
                  rot_left_d = '0;
               end else if (!hold) begin
                  step_en_c = 1'b1;
                  if (step_q == STEP_W'(STEP_LAST)) begin
                     step_d     = '0;
                     rot_left_d = rot_left_q - CNT_W'(1);
                  end else begin
                     step_d = step_q + STEP_W'(1);
                  end
               end
            end
            ST_PAUSE: begin
               if (abort) begin
                  clr_c      = 1'b1;
                  step_d     = '0;
                  rot_left_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Counters and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q     <= '0;
         rot_left_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         step_q     <= step_d;
         rot_left_q <= rot_left_d;
         busy_q     <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rot_left = rot_left_q;

endmodule : johnson_seq_ctrl

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: scoreboard bench for johnson_seq_ctrl. A reference
// model predicts every cycle's outputs (phase from the total step count) and
// each sequence's busy length; a monitor compares on the falling edge.
module tb_johnson_seq_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned CNT_W = 8;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   typedef struct {
      logic [N-1:0]     phase;
      logic             busy;
      logic             done;
      logic [CNT_W-1:0] rot;
      logic             err;
   } snap_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] rotations;
   logic             hold;
   logic             abort;
   logic [N-1:0]     phase;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] rot_left;
   logic             err;

   snap_t snap_q[$];
   int    txn_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int busy_run  = 0;
   int last_busy = -1;
   int done_cnt  = 0;
   bit model_en  = 1'b1;

   int m_mode  = M_IDLE;
   int m_r     = 0;
   int m_steps = 0;
   int m_busy  = 0;

   johnson_seq_ctrl #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rotations (rotations),
      .hold      (hold),
      .abort     (abort),
      .phase     (phase),
      .busy      (busy),
      .done      (done),
      .rot_left  (rot_left),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Johnson pattern after k steps from the zero seed: ones fill in from the
   // MSB for the first N steps, then drain away from the MSB.
   function automatic logic [N-1:0] jphase(input int k);
      int           m;
      logic [N-1:0] p;
      m = k % (2 * N);
      p = '0;
      for (int i = 0; i < N; i++) begin
         if (m <= N) begin
            if (i >= N - m) p[i] = 1'b1;
         end else begin
            if (i < 2 * N - m) p[i] = 1'b1;
         end
      end
      return p;
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_reset(input string name);
      n_cmp++;
      if (phase !== '0 || busy !== 1'b0 || done !== 1'b0 || rot_left !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: phase=%b busy=%b done=%b rot_left=%0d err=%b, required all zero",
                  name, phase, busy, done, rot_left, err);
      end
   endtask

   // Reference model: advances on each rising edge and queues the outputs
   // expected for the following cycle.
   always @(posedge clk) begin
      if (model_en) begin
         snap_t s;
         if (rst) begin
            m_mode = M_IDLE; m_r = 0; m_steps = 0; m_busy = 0;
         end else begin
            if (m_mode == M_RUN || m_mode == M_PAUSE) m_busy++;
            case (m_mode)
               M_IDLE: begin
                  if (start && !abort) begin
                     m_busy = 0;
                     if (rotations == '0) begin
                        m_mode = M_DONE;
                        txn_q.push_back(0);
                     end else begin
                        m_r = int'(rotations); m_steps = 0; m_mode = M_RUN;
                     end
                  end
               end
               M_RUN: begin
                  if (abort) begin
                     m_mode = M_IDLE; m_r = 0; m_steps = 0;
                  end else if (hold) begin
                     m_mode = M_PAUSE;
                  end else begin
                     m_steps++;
                     if (m_steps == m_r * 2 * N) begin
                        m_mode = M_DONE;
                        txn_q.push_back(m_busy);
                     end
                  end
               end
               M_PAUSE: begin
                  if (abort) begin
                     m_mode = M_IDLE; m_r = 0; m_steps = 0;
                  end else if (!hold) begin
                     m_mode = M_RUN;
                  end
               end
               default: begin
                  m_mode = M_IDLE; m_r = 0; m_steps = 0;
               end
            endcase
         end
         s.phase = jphase(m_steps);
         s.busy  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
         s.done  = (m_mode == M_DONE);
         s.rot   = CNT_W'(m_r - m_steps / (2 * N));
         s.err   = 1'b0;
         snap_q.push_back(s);
      end
   end

   // Monitor: per-cycle snapshot check plus busy-length check on each done.
   always @(negedge clk) begin
      if (snap_q.size() > 0) begin
         snap_t e;
         e = snap_q.pop_front();
         n_cmp++;
         if (phase !== e.phase || busy !== e.busy || done !== e.done ||
             rot_left !== e.rot || err !== e.err) begin
            n_fail++;
            $display("FAIL snapshot @%0t: phase=%b busy=%b done=%b rot_left=%0d err=%b, required phase=%b busy=%b done=%b rot_left=%0d err=%b",
                     $time, phase, busy, done, rot_left, err, e.phase, e.busy, e.done, e.rot, e.err);
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (txn_q.size() == 0) begin
            chk(1'b0, "unexpected_done", 1, 0);
         end else begin
            int exp_b;
            exp_b = txn_q.pop_front();
            chk(busy_run == exp_b, "busy_length", busy_run, exp_b);
         end
         last_busy = busy_run;
         busy_run  = 0;
      end else if (busy === 1'b1) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // One call = one sampled rising edge with these inputs.
   task automatic drive(input logic s, input int r, input logic h, input logic a);
      start     = s;
      rotations = CNT_W'(r);
      hold      = h;
      abort     = a;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int dc;
      rst = 1'b1; start = 1'b0; rotations = '0; hold = 1'b0; abort = 1'b0;
      #1;
      check_reset("reset_async_t0");
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Single rotation: eight busy cycles.
      last_busy = -1;
      drive(1'b1, 1, 1'b0, 1'b0);
      idle(10);
      chk(last_busy == 8, "r1_busy_cycles", last_busy, 8);

      // Three rotations with start/rotations noise while running.
      last_busy = -1;
      drive(1'b1, 3, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), 1'b0, 1'b0);
      idle(4);
      chk(last_busy == 24, "r3_busy_cycles", last_busy, 24);

      // Hold at phase 1110 for five frozen cycles.
      last_busy = -1;
      drive(1'b1, 2, 1'b0, 1'b0);
      idle(3);
      chk(phase == 4'b1110, "hold_entry_phase", int'(phase), 14);
      repeat (4) drive(1'b0, 0, 1'b1, 1'b0);
      chk(busy == 1'b1 && phase == 4'b1110, "hold_frozen", int'(phase), 14);
      idle(20);
      chk(last_busy == 21, "hold_busy_cycles", last_busy, 21);

      // Abort on step 5 (with start), then abort+start in IDLE.
      dc = done_cnt;
      drive(1'b1, 2, 1'b0, 1'b0);
      idle(4);
      drive(1'b1, 3, 1'b0, 1'b1);
      chk(busy == 1'b0 && phase == '0 && rot_left == '0, "abort_to_idle", int'(busy), 0);
      drive(1'b1, 2, 1'b0, 1'b1);
      idle(3);
      chk(done_cnt == dc, "abort_no_done", done_cnt, dc);

      // Zero rotations: done next cycle, never busy.
      last_busy = -1;
      drive(1'b1, 0, 1'b0, 1'b0);
      chk(done == 1'b1, "r0_done_next", int'(done), 1);
      idle(2);
      chk(last_busy == 0, "r0_never_busy", last_busy, 0);

      // Asynchronous reset mid-sequence.
      dc = done_cnt;
      drive(1'b1, 2, 1'b0, 1'b0);
      idle(5);
      #2;
      rst = 1'b1;
      #1;
      check_reset("reset_async_mid");
      @(negedge clk);
      #1;
      rst = 1'b0;
      idle(20);
      chk(done_cnt == dc, "reset_no_done", done_cnt, dc);

      // Randomized traffic.
      repeat (400) begin
         drive(1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 39) == 0));
      end
      idle(40);
      chk(txn_q.size() == 0, "pending_done", txn_q.size(), 0);
      chk(busy == 1'b0, "drained_idle", int'(busy), 0);

`ifdef JSEQ_ILLEGAL_DET_EN
      // Corrupt the phase register and expect detection.
      model_en = 1'b0;
      @(negedge clk);
      force u_dut.u_core.phase = 4'b0101;
      #3;
      release u_dut.u_core.phase;
      @(posedge clk);
      #1;
      chk(err == 1'b1 && phase == '0 && busy == 1'b0, "illegal_detect", int'(err), 1);
      @(negedge clk);
      #1;
      idle(3);
      chk(err == 1'b1, "illegal_sticky", int'(err), 1);
      rst = 1'b1;
      model_en = 1'b1;
      idle(1);
      rst = 1'b0;
      chk(err == 1'b0, "illegal_cleared", int'(err), 0);
      idle(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_johnson_seq_ctrl
